program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 124 ++++++++++++
 tb/tb_program_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: streams a little-endian word image into a computer's memory, runs it
// with a cycle timeout, then reads a fixed memory window back out as a word stream.
module program_loader #(
   parameter int unsigned TIMEOUT   = 65535,
   parameter logic [7:0]  DUMP_BASE = 8'hF0,
   parameter int unsigned DUMP_LEN  = 16
) (
   input  logic        clk,
   input  logic        Rst,
   input  logic        Start,
   input  logic [7:0]  Load_Len,
   input  logic [7:0]  In_Byte,
   input  logic        In_Valid,
   output logic        In_Ready,
   output logic        TBorNot,
   output logic [7:0]  Tb_MEMAddr,
   output logic [15:0] Tb_MEMData,
   output logic        Tb_MEMWE,
   output logic        CPU_Rst,
   input  logic        Done,
   input  logic [15:0] OutMEM,
   output logic [15:0] Out_Word,
   output logic        Out_Valid,
   input  logic        Out_Ready,
   output logic        Busy,
   output logic        Error
);
   typedef enum logic [2:0] {
      IDLE, LOAD_LO, LOAD_HI, WRITE, RUN, DUMP_ADDR, DUMP_WAIT, DUMP_OUT
   } state_t;

   state_t      state, state_n;
   logic [7:0]  addr_cnt, lo, mem_addr;
   logic [8:0]  word_cnt, len, idx;
   logic [15:0] mem_data, word;
   logic [31:0] cyc;
   logic        last_word, timeout_hit, last_dump;

   assign last_word   = (word_cnt + 9'd1) == len;
   assign timeout_hit = cyc == TIMEOUT - 1;
   assign last_dump   = (idx + 9'd1) == 9'(DUMP_LEN);

   // Strobes decode straight from state so a reset removes them without waiting for a clock.
   assign In_Ready   = state == LOAD_LO || state == LOAD_HI;
   assign Tb_MEMWE   = state == WRITE;
   assign TBorNot    = state != IDLE && state != RUN;
   assign CPU_Rst    = state != RUN;
   assign Busy       = state != IDLE;
   assign Out_Valid  = state == DUMP_OUT;
   assign Tb_MEMAddr = mem_addr;
   assign Tb_MEMData = mem_data;
   assign Out_Word   = word;

   always_ff @(posedge clk or posedge Rst)
      if (Rst) state <= IDLE;
      else     state <= state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:      state_n = Start ? LOAD_LO : IDLE;
         LOAD_LO:   state_n = In_Valid ? LOAD_HI : LOAD_LO;
         LOAD_HI:   state_n = In_Valid ? WRITE : LOAD_HI;
         WRITE:     state_n = last_word ? RUN : LOAD_LO;
         RUN:       state_n = (Done || timeout_hit) ? DUMP_ADDR : RUN;
         DUMP_ADDR: state_n = DUMP_WAIT;
         DUMP_WAIT: state_n = DUMP_OUT;
         DUMP_OUT:  state_n = Out_Ready ? (last_dump ? IDLE : DUMP_ADDR) : DUMP_OUT;
         default:   state_n = IDLE;
      endcase
   end

   // Memory port registers load one cycle early so WRITE/DUMP_ADDR present settled values.
   always_ff @(posedge clk or posedge Rst)
      if (Rst) begin
         addr_cnt <= '0;
         word_cnt <= '0;
         len      <= '0;
         lo       <= '0;
         mem_addr <= '0;
         mem_data <= '0;
         word     <= '0;
         idx      <= '0;
         cyc      <= '0;
         Error    <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (Start) begin
                  addr_cnt <= '0;
                  word_cnt <= '0;
                  idx      <= '0;
                  len      <= {Load_Len == 8'd0, Load_Len};
                  Error    <= 1'b0;
               end
            LOAD_LO:
               if (In_Valid) lo <= In_Byte;
            LOAD_HI:
               if (In_Valid) begin
                  mem_addr <= addr_cnt;
                  mem_data <= {In_Byte, lo};
               end
            WRITE: begin
               addr_cnt <= addr_cnt + 8'd1;
               word_cnt <= word_cnt + 9'd1;
               cyc      <= '0;
            end
            RUN:
               if (Done || timeout_hit) begin
                  mem_addr <= DUMP_BASE;
                  Error    <= !Done;
               end else
                  cyc <= cyc + 32'd1;
            DUMP_WAIT:
               word <= OutMEM;
            DUMP_OUT:
               if (Out_Ready) begin
                  idx      <= idx + 9'd1;
                  mem_addr <= DUMP_BASE + idx[7:0] + 8'd1;
               end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed tests of program_loader against a bench memory model.
module tb_program_loader;
   logic        clk = 0, Rst = 0, Start = 0, In_Valid = 0, Done = 0, Out_Ready = 1;
   logic [7:0]  Load_Len = 0, In_Byte = 0, Tb_MEMAddr;
   logic [15:0] Tb_MEMData, OutMEM = 0, Out_Word;
   logic        In_Ready, TBorNot, Tb_MEMWE, CPU_Rst, Out_Valid, Busy, Error;

   int pass_cnt = 0, total = 0, nwr = 0;
   logic [15:0] mem [256];
   logic [7:0]  wa [16];
   logic [15:0] wd [16];
   logic [15:0] outs [16];

   program_loader #(.TIMEOUT(20), .DUMP_BASE(8'hF0), .DUMP_LEN(16)) dut (
      .clk(clk), .Rst(Rst), .Start(Start), .Load_Len(Load_Len),
      .In_Byte(In_Byte), .In_Valid(In_Valid), .In_Ready(In_Ready),
      .TBorNot(TBorNot), .Tb_MEMAddr(Tb_MEMAddr), .Tb_MEMData(Tb_MEMData),
      .Tb_MEMWE(Tb_MEMWE), .CPU_Rst(CPU_Rst), .Done(Done), .OutMEM(OutMEM),
      .Out_Word(Out_Word), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
      .Busy(Busy), .Error(Error)
   );

   always #5 clk = ~clk;

   // memory of the computer: synchronous write, one-cycle read latency
   always @(posedge clk) begin
      if (Tb_MEMWE === 1'b1) begin
         mem[Tb_MEMAddr] <= Tb_MEMData;
         if (nwr < 16) begin
            wa[nwr] = Tb_MEMAddr;
            wd[nwr] = Tb_MEMData;
         end
         nwr = nwr + 1;
      end
      OutMEM <= mem[Tb_MEMAddr];
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [7:0] len);
      Start = 1;
      Load_Len = len;
      step();
      Start = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      In_Valid = 0;
      repeat (gap) step();
      In_Byte = b;
      In_Valid = 1;
      t = 0;
      while (In_Ready !== 1'b1 && t < 50) begin
         step();
         t++;
      end
      total++;
      if (t >= 50) $display("FAIL byte_accept: In_Ready=%b required 1", In_Ready);
      else pass_cnt++;
      step();
      In_Valid = 0;
   endtask

   task automatic run_phase(input int done_at, output int cycles);
      int t = 0;
      while (CPU_Rst !== 1'b0 && t < 50) begin
         step();
         t++;
      end
      total++;
      if (CPU_Rst !== 1'b0) $display("FAIL run_entry: CPU_Rst=%b required 0", CPU_Rst);
      else pass_cnt++;
      cycles = 0;
      while (CPU_Rst === 1'b0 && cycles < 100) begin
         if (cycles == done_at) Done = 1;
         cycles++;
         step();
      end
      Done = 0;
   endtask

   task automatic drain(input int hold_at, input logic exp_err);
      int got = 0, held = 0, t = 0, bad = 0;
      while (got < 16 && t < 400) begin
         Out_Ready = !(got == hold_at && held < 5);
         if (got == hold_at && held < 5 && (held > 0 || Out_Valid === 1'b1)) begin
            total++;
            if (Out_Valid !== 1'b1 || Out_Word !== 16'(hold_at))
               $display("FAIL hold_stable: valid=%b word=%h required valid=1 word=%h",
                        Out_Valid, Out_Word, 16'(hold_at));
            else pass_cnt++;
            held++;
         end
         if (Out_Valid === 1'b1 && Out_Ready) begin
            outs[got] = Out_Word;
            got++;
         end
         step();
         t++;
      end
      Out_Ready = 1;
      for (int i = 0; i < 16; i++) if (i >= got || outs[i] !== 16'(i)) bad++;
      total++;
      if (got != 16 || bad != 0) $display("FAIL dump_words: got=%0d bad=%0d required 16 words 0..15", got, bad);
      else pass_cnt++;
      total++;
      if (Busy !== 1'b0 || Error !== exp_err)
         $display("FAIL dump_end: Busy=%b Error=%b required Busy=0 Error=%b", Busy, Error, exp_err);
      else pass_cnt++;
   endtask

   task automatic check_writes(input string name);
      total++;
      if (nwr != 2 || wa[0] !== 8'h00 || wd[0] !== 16'h1234 || wa[1] !== 8'h01 || wd[1] !== 16'hABCD)
         $display("FAIL %s: n=%0d (%h,%h) (%h,%h) required n=2 (00,1234) (01,abcd)",
                  name, nwr, wa[0], wd[0], wa[1], wd[1]);
      else pass_cnt++;
   endtask

   task automatic check_reset_outputs(input string name);
      total++;
      if (TBorNot !== 0 || Tb_MEMWE !== 0 || Tb_MEMAddr !== 8'h00 || Tb_MEMData !== 16'h0000 ||
          CPU_Rst !== 1 || In_Ready !== 0 || Out_Valid !== 0 || Out_Word !== 16'h0000 ||
          Busy !== 0 || Error !== 0)
         $display("FAIL %s: tb=%b we=%b a=%h d=%h cr=%b ir=%b ov=%b ow=%h busy=%b err=%b required 0 0 00 0000 1 0 0 0000 0 0",
                  name, TBorNot, Tb_MEMWE, Tb_MEMAddr, Tb_MEMData, CPU_Rst, In_Ready, Out_Valid, Out_Word, Busy, Error);
      else pass_cnt++;
   endtask

   task automatic test_reset;
      #2 Rst = 1;
      #1 check_reset_outputs("reset_state");
      #3 Rst = 0;
      step();
      Done = 1;
      repeat (3) step();
      total++;
      if (Busy !== 0 || CPU_Rst !== 1) $display("FAIL done_in_idle: Busy=%b CPU_Rst=%b required 0 1", Busy, CPU_Rst);
      else pass_cnt++;
      Done = 0;
   endtask

   task automatic test_load_run_dump;
      int cyc;
      nwr = 0;
      start(8'd2);
      total++;
      if (In_Ready !== 1 || TBorNot !== 1 || Busy !== 1)
         $display("FAIL load_lo_outputs: ir=%b tb=%b busy=%b required 1 1 1", In_Ready, TBorNot, Busy);
      else pass_cnt++;
      send_byte(8'h34, 0);
      send_byte(8'h12, 0);
      send_byte(8'hCD, 0);
      send_byte(8'hAB, 0);
      run_phase(10, cyc);
      check_writes("writes_b2b");
      total++;
      if (cyc != 11) $display("FAIL run_len_done: cycles=%0d required 11", cyc);
      else pass_cnt++;
      drain(-1, 1'b0);
   endtask

   task automatic test_gaps;
      int cyc;
      nwr = 0;
      start(8'd2);
      send_byte(8'h34, 3);
      send_byte(8'h12, 3);
      send_byte(8'hCD, 3);
      send_byte(8'hAB, 3);
      run_phase(10, cyc);
      check_writes("writes_gapped");
      drain(-1, 1'b0);
   endtask

   task automatic test_timeout_hold;
      int cyc;
      start(8'd1);
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      run_phase(-1, cyc);
      total++;
      if (cyc != 20 || Error !== 1 || CPU_Rst !== 1 || TBorNot !== 1)
         $display("FAIL timeout: cycles=%0d err=%b cr=%b tb=%b required 20 1 1 1", cyc, Error, CPU_Rst, TBorNot);
      else pass_cnt++;
      drain(3, 1'b1);
   endtask

   task automatic test_tie_and_restart;
      int cyc;
      start(8'd1);
      total++;
      if (Error !== 0) $display("FAIL start_clears_error: Error=%b required 0", Error);
      else pass_cnt++;
      Done = 1;
      repeat (3) step();
      total++;
      if (In_Ready !== 1 || CPU_Rst !== 1) $display("FAIL done_in_load: ir=%b cr=%b required 1 1", In_Ready, CPU_Rst);
      else pass_cnt++;
      Done = 0;
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      run_phase(19, cyc);
      total++;
      if (cyc != 20 || Error !== 0) $display("FAIL done_wins_tie: cycles=%0d err=%b required 20 0", cyc, Error);
      else pass_cnt++;
      drain(-1, 1'b0);
   endtask

   task automatic test_reset_mid_load;
      int cyc;
      nwr = 0;
      start(8'd2);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      total++;
      if (nwr != 1 || In_Ready !== 1 || Busy !== 1)
         $display("FAIL pre_reset: n=%0d ir=%b busy=%b required 1 1 1", nwr, In_Ready, Busy);
      else pass_cnt++;
      Rst = 1;
      #1 check_reset_outputs("async_reset_mid");
      #1 Rst = 0;
      step();
      nwr = 0;
      start(8'd1);
      send_byte(8'h78, 0);
      send_byte(8'h56, 0);
      run_phase(0, cyc);
      total++;
      if (nwr != 1 || wa[0] !== 8'h00 || wd[0] !== 16'h5678)
         $display("FAIL restart_write: n=%0d (%h,%h) required n=1 (00,5678)", nwr, wa[0], wd[0]);
      else pass_cnt++;
      drain(-1, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
      for (int i = 0; i < 16; i++) mem[8'hF0 + i] = 16'(i);
      test_reset();
      test_load_run_dump();
      test_gaps();
      test_timeout_hold();
      test_tie_and_restart();
      test_reset_mid_load();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
